// File: rtl/seq_1001_framer_tx_if.sv
// ----------------------------------------------------------------------------
// seq_1001_framer_tx_if
// Payload handshake between an upstream word source and the 1001 framer.
//   in_valid  source -> framer   payload word available
//   in_ready  framer -> source   framer can take a word this cycle
//   in_data   source -> framer   payload word, DATA_W bits
// Modports: master = upstream source, slave = framer.
// ----------------------------------------------------------------------------
interface seq_1001_framer_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/seq_1001_framer_tx.sv
// ----------------------------------------------------------------------------
// seq_1001_framer_tx
// Transmit side of the 1001 sync-marker serial link. Each accepted payload
// word is sent MSB first behind the 4-bit header 1001; the line idles at 0
// and every frame is followed by IDLE_BITS forced zero bits.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_if        slave side of the valid/ready payload handshake
//   tx_bit       serial line to the detector
//   tx_active    high while header or payload bits are on tx_bit
//   frame_done   1-cycle pulse while the payload LSB is on tx_bit
//   frame_count  completed frames, modulo 2^CNT_W
// ----------------------------------------------------------------------------
module seq_1001_framer_tx #(
    parameter int DATA_W    = 8,
    parameter int IDLE_BITS = 2,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    seq_1001_framer_tx_if.slave    in_if,
    output logic                   tx_bit,
    output logic                   tx_active,
    output logic                   frame_done,
    output logic [CNT_W-1:0]       frame_count
);
    localparam int            FRAME_W  = DATA_W + 4;
    localparam int            CW       = $clog2(FRAME_W);
    localparam int            GW       = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((IDLE_BITS > 0) ? IDLE_BITS - 1 : 0);
    localparam logic [3:0]    SYNC     = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [CW-1:0]      bit_q,   bit_d;
    logic [GW-1:0]      gap_q,   gap_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // NOTE: every variable gets its hold value before the case, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        count_d = count_q;

        unique case (state_q)
            S_IDLE: begin
                // in_ready is high in IDLE, so in_valid alone means accept.
                if (in_if.in_valid) begin
                    shift_d = {SYNC, in_if.in_data};
                    bit_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                bit_d   = bit_q + 1'b1;
                if (bit_q == LAST_BIT) begin
                    count_d = count_q + 1'b1;
                    gap_d   = '0;
                    state_d = (IDLE_BITS == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            gap_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            count_q <= count_d;
        end
    end

    // NOTE: the shift register is pure datapath; it is only observed in SEND,
    // which is always entered through a load, so it needs no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    // Outputs are forced quiet while reset is high so the line is clean even
    // before the first reset edge and during a mid-frame reset cycle.
    assign in_if.in_ready = !reset && (state_q == S_IDLE);
    assign tx_active      = !reset && (state_q == S_SEND);
    assign tx_bit         = tx_active && shift_q[FRAME_W-1];
    assign frame_done     = tx_active && (bit_q == LAST_BIT);
    assign frame_count    = reset ? '0 : count_q;

endmodule

// File: tb/tb_seq_1001_framer_tx.sv
// ----------------------------------------------------------------------------
// tb_seq_1001_framer_tx
// Bench for seq_1001_framer_tx. A second instance with CNT_W=2 shares the
// stimulus to exercise frame_count wrap. The reference keeps a queue of
// scheduled line symbols per accepted word (header+payload, then gap zeros);
// an empty queue means the framer is idle and ready.
// ----------------------------------------------------------------------------
module tb_seq_1001_framer_tx;
    localparam int DATA_W    = 8;
    localparam int IDLE_BITS = 2;
    localparam int CNT_W     = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seq_1001_framer_tx_if #(.DATA_W(DATA_W)) in_if ();
    seq_1001_framer_tx_if #(.DATA_W(DATA_W)) in_if2 ();
    assign in_if2.in_valid = in_if.in_valid;
    assign in_if2.in_data  = in_if.in_data;

    logic             tx_bit, tx_active, frame_done;
    logic [CNT_W-1:0] frame_count;
    logic             tx_bit2, tx_active2, frame_done2;
    logic [1:0]       frame_count2;

    seq_1001_framer_tx #(.DATA_W(DATA_W), .IDLE_BITS(IDLE_BITS), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_if(in_if.slave),
        .tx_bit(tx_bit), .tx_active(tx_active), .frame_done(frame_done),
        .frame_count(frame_count)
    );

    seq_1001_framer_tx #(.DATA_W(DATA_W), .IDLE_BITS(IDLE_BITS), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_if(in_if2.slave),
        .tx_bit(tx_bit2), .tx_active(tx_active2), .frame_done(frame_done2),
        .frame_count(frame_count2)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic b;
        logic act;
        logic done;
    } sym_t;

    sym_t                q[$];
    logic [31:0]         model_cnt = '0;
    logic [DATA_W+3:0]   mframe;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            model_cnt = '0;
        end else if (q.size() > 0) begin
            if (q[0].done) model_cnt = model_cnt + 1;
            void'(q.pop_front());
        end else if (in_if.in_valid) begin
            mframe = {4'b1001, in_if.in_data};
            for (int i = DATA_W + 3; i >= 0; i--) q.push_back('{mframe[i], 1'b1, (i == 0)});
            for (int i = 0; i < IDLE_BITS; i++) q.push_back('{1'b0, 1'b0, 1'b0});
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        sym_t        e;
        logic        rdy;
        logic [31:0] fc;
        e   = (!reset && q.size() > 0) ? q[0] : '0;
        rdy = !reset && (q.size() == 0);
        fc  = reset ? 32'd0 : model_cnt;
        check("tx_bit",       tx_bit,          e.b);
        check("tx_active",    tx_active,       e.act);
        check("frame_done",   frame_done,      e.done);
        check("in_ready",     in_if.in_ready,  rdy);
        check("frame_count",  frame_count,     fc[CNT_W-1:0]);
        check("tx_bit_w2",    tx_bit2,         e.b);
        check("in_ready_w2",  in_if2.in_ready, rdy);
        check("fc_w2",        frame_count2,    fc[1:0]);
    end

    // ---------------- directed + random stimulus ----------------
    task automatic wait_ready();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_if.in_ready === 1'b1) return;
        end
        check("ready_timeout", 32'd0, 32'd1);
    endtask

    logic [14:0] rec15, done15, rdy15;
    logic [26:0] rec27;
    logic [3:0]  rec4, win;
    logic [9:0]  fcs;
    int          hits, got;
    logic        prev_done;

    initial begin
        in_if.in_valid = 1'b1;
        in_if.in_data  = 8'hA5;

        // Test 1: reset held 3 cycles with in_valid high.
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", in_if.in_ready, 1'b0);
            check("rst_tx",    tx_bit,         1'b0);
            check("rst_fc",    frame_count,    '0);
        end
        #1 reset = 1'b0;
        #1 check("ready_after_rst", in_if.in_ready, 1'b1);

        // Test 2: 8'hA5 accepted on the first IDLE edge.
        @(posedge clk);
        #1 in_if.in_valid = 1'b0;
        rec15 = '0; done15 = '0; rdy15 = '0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            rec15  = {rec15[13:0],  tx_bit};
            done15 = {done15[13:0], frame_done};
            rdy15  = {rdy15[13:0],  in_if.in_ready};
        end
        check("a5_bits",  rec15,       15'b100110100101000);
        check("a5_done",  done15,      15'b000000000001000);
        check("a5_ready", rdy15,       15'b000000000000001);
        check("a5_fc",    frame_count, 16'd1);

        // Test 3: back-to-back 8'h00 then 8'hFF, in_data churns mid-frame.
        #1 in_if.in_valid = 1'b1;
        in_if.in_data = 8'h00;
        @(posedge clk);
        #1 in_if.in_data = DATA_W'($urandom);
        rec27 = '0;
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            rec27 = {rec27[25:0], tx_bit};
            @(posedge clk);
            #1;
            if (c < 14)       in_if.in_data  = DATA_W'($urandom);
            else if (c == 14) in_if.in_data  = 8'hFF;
            else if (c == 15) in_if.in_valid = 1'b0;
        end
        check("b2b_bits", rec27, 27'b100100000000000100111111111);

        // Test 4: reset during the payload of 8'hFF.
        wait_ready();
        #1 in_if.in_valid = 1'b1;
        in_if.in_data = 8'hFF;
        @(posedge clk);
        #1 in_if.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        @(negedge clk);
        check("mid_tx_before", tx_bit, 1'b1);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_tx_after", tx_bit,      1'b0);
        check("mid_done",     frame_done,  1'b0);
        check("mid_fc",       frame_count, '0);
        #1 in_if.in_valid = 1'b1;
        in_if.in_data = 8'hA5;
        @(posedge clk);
        #1 in_if.in_valid = 1'b0;
        rec4 = '0;
        repeat (4) begin
            @(negedge clk);
            rec4 = {rec4[2:0], tx_bit};
        end
        check("clean_header", rec4, 4'b1001);

        // Test 5: four frames of 8'h00; a 1001 window on the line per frame.
        wait_ready();
        #1 in_if.in_valid = 1'b1;
        in_if.in_data = 8'h00;
        @(posedge clk);
        win = '0; hits = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            win = {win[2:0], tx_bit};
            if (win == 4'b1001) hits++;
            @(posedge clk);
            #1;
            if (c == 46) in_if.in_valid = 1'b0;
        end
        check("sync_hits", hits, 32'd4);

        // Test 6: CNT_W=2 instance counts 1,2,3,0,1 over five frames.
        wait_ready();
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        in_if.in_valid = 1'b1;
        in_if.in_data  = DATA_W'($urandom);
        got = 0; prev_done = 1'b0; fcs = '0;
        for (int c = 0; c < 150 && got < 5; c++) begin
            @(negedge clk);
            if (prev_done) begin
                fcs = {fcs[7:0], frame_count2};
                got++;
            end
            prev_done = frame_done2;
        end
        #1 in_if.in_valid = 1'b0;
        check("w2_frames", got, 32'd5);
        check("w2_seq",    fcs, 10'b01_10_11_00_01);

        // Random phase: random valid/data with occasional resets.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            in_if.in_valid = ($urandom_range(0, 3) != 0);
            in_if.in_data  = DATA_W'($urandom);
            reset          = ($urandom_range(0, 149) == 0);
        end
        #1 reset = 1'b0;
        in_if.in_valid = 1'b0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end
endmodule
